unidad_de_busqueda: RTL and testbench
=====================================

// Module: unidad_de_busqueda
// PURPOSE
//  Instruction fetch/decode front end; the consumer side of the jump unit's instruction-address bus.
//  Samples the PC from i_Bus_Direcciones_Instrucciones, reads program memory over a ready handshake,
//  and latches the instruction word. For jump opcodes it drives Direccion_de_Salto and Condicion back
//  to the jump unit as a one-cycle pulse, which closes the PC loop.
// PARAMETERS
//  ANCHO_DIR     8     address width (PC / jump target)
//  ANCHO_INSTR   16    instruction word width
//  OPCODE_SALTO  4'hF  opcode (instr[15:12]) identifying a jump
//  ESPERA_MAX    15    max WAIT cycles before timeout (1..255)
// PORTS
//  Clk                             in   1            system clock, rising edge
//  Rst                             in   1            asynchronous reset, active-low
//  i_Bus_Direcciones_Instrucciones in   ANCHO_DIR    current PC from the jump unit
//  i_Detener                       in   1            stall: no new fetch starts while high
//  o_Mem_Direccion                 out  ANCHO_DIR    program-memory address
//  o_Mem_Lectura                   out  1            read request to program memory
//  i_Mem_Dato                      in   ANCHO_INSTR  instruction word from memory
//  i_Mem_Listo                     in   1            i_Mem_Dato valid this cycle
//  o_Instruccion                   out  ANCHO_INSTR  latched instruction register
//  o_Instruccion_Valida            out  1            one-cycle pulse: o_Instruccion is new
//  o_Direccion_de_Salto            out  ANCHO_DIR    jump target = instr[7:0]
//  o_Condicion                     out  4            {enable, cond[2:0]}; 4'b0000 = no jump
//  o_Error                         out  1            sticky memory-timeout flag
// BEHAVIOUR
//  Reset (Rst=0, async, any state): state=IDLE, all outputs 0, IR=0, timeout counter=0, o_Error=0.
//  FSM states and transitions:
//   IDLE:   if !i_Detener -> REQ and o_Mem_Direccion <= i_Bus_Direcciones_Instrucciones; else stay IDLE.
//   REQ:    o_Mem_Lectura=1. i_Mem_Listo=1 -> DECODE (IR <= i_Mem_Dato). Otherwise -> WAIT, counter <= 1.
//   WAIT:   o_Mem_Lectura=1. i_Mem_Listo=1 -> DECODE (IR <= i_Mem_Dato), counter <= 0.
//           If counter==ESPERA_MAX and !i_Mem_Listo: o_Error <= 1, counter <= 0, -> REQ (retry, same address).
//           Otherwise counter increments.
//   DECODE: one cycle only, then -> IDLE. o_Instruccion_Valida=1.
//           If IR[15:12]==OPCODE_SALTO: o_Condicion={1'b1,IR[10:8]}, o_Direccion_de_Salto=IR[7:0].
//           Else: o_Condicion=4'b0000, o_Direccion_de_Salto=0.
//  Outside DECODE: o_Instruccion_Valida=0 and o_Condicion=4'b0000. o_Instruccion keeps its last value.
//  Latency: with the memory ready in REQ, PC sample to decode pulse = 2 cycles; each WAIT cycle adds 1.
//  PC is re-sampled only in IDLE, which always follows DECODE. This gives the jump unit exactly one
//   edge to update the PC before the next fetch. No speculative fetch, so no flush is needed.
//  o_Mem_Direccion is registered and stable from REQ through DECODE; it changes only on IDLE->REQ.
//  i_Detener is sampled only in IDLE; a stall asserted mid-fetch takes effect after DECODE.
//  i_Mem_Listo is ignored in IDLE and DECODE.
//  Timeout wins over nothing: i_Mem_Listo in the same cycle as counter==ESPERA_MAX -> DECODE, no error.
//  o_Error stays high until reset. A retry after timeout does not clear it.
//  IR[11] is reserved and ignored by decode.
//  All outputs are registered or decoded from the state register and IR only; no comb path from inputs.
// STRUCTURE
//  Shared package: state encodings (IDLE, REQ, WAIT, DECODE as 2-bit constants), OPCODE_SALTO,
//   the condition-enable bit position, and the instruction field slices ([15:12], [10:8], [7:0]).
//   The jump unit uses the same package.
//  Single sub-module: decodificador_salto (combinational: IR -> o_Condicion / o_Direccion_de_Salto),
//   qualified by state==DECODE in the parent.
// TESTING
//  1 Reset: hold Rst=0 for 2 cycles mid-WAIT -> all outputs 0 immediately; after release,
//    IDLE then REQ with o_Mem_Direccion equal to the PC.
//  2 Zero-wait fetch: PC=8'h07, memory returns 16'h1234 with i_Mem_Listo in REQ
//    -> next cycle o_Instruccion=16'h1234, o_Instruccion_Valida=1, o_Condicion=4'b0000.
//  3 Jump decode: memory returns 16'hF507 after 3 WAIT cycles
//    -> DECODE pulse with o_Condicion=4'b1101 and o_Direccion_de_Salto=8'h07 for exactly 1 cycle.
//    Next IDLE samples the updated PC.
//  4 Timeout: i_Mem_Listo held low with ESPERA_MAX=15 -> o_Error rises after 15 WAIT cycles,
//    then REQ re-issues the same address. Listo on the retry -> normal DECODE; o_Error remains 1.
//  5 Stall: i_Detener=1 during DECODE -> FSM parks in IDLE and o_Mem_Lectura=0 while stalled.
//    Release -> REQ on the next edge with the current PC.
//  6 Boundary: PC=8'hFF then PC=8'h00 (wrap from the jump unit) -> both fetched addresses appear
//    verbatim on o_Mem_Direccion. Listo asserted in IDLE is ignored (no DECODE pulse).

Source files
------------

// File: rtl/unidad_de_busqueda_pkg.sv
`default_nettype none
// ============================================================================
// Module   : unidad_de_busqueda_pkg
// Brief    : Shared fetch/jump encodings: FSM states, jump opcode, field slices
// Revision : 1.0
// ============================================================================
package unidad_de_busqueda_pkg;

    localparam int          c_ancho_estado = 2;
    localparam logic [1:0]  c_st_idle      = 2'd0;
    localparam logic [1:0]  c_st_req       = 2'd1;
    localparam logic [1:0]  c_st_wait      = 2'd2;
    localparam logic [1:0]  c_st_decode    = 2'd3;

    localparam logic [3:0]  c_opcode_salto = 4'hF;
    localparam int          c_bit_habilita = 3;

    // Instruction field slices; bit 11 is reserved and never decoded.
    localparam int          c_opc_msb      = 15;
    localparam int          c_opc_lsb      = 12;
    localparam int          c_cond_msb     = 10;
    localparam int          c_cond_lsb     = 8;
    localparam int          c_dir_msb      = 7;
    localparam int          c_dir_lsb      = 0;

    typedef struct packed {
        logic [3:0] condicion;
        logic [7:0] direccion;
    } salto_t;

endpackage : unidad_de_busqueda_pkg
`default_nettype wire

// File: rtl/unidad_de_busqueda_decodificador_salto.sv
`default_nettype none
// ============================================================================
// Module   : decodificador_salto
// Brief    : Combinational jump decode of the instruction fields
// Revision : 1.0
// ============================================================================
module decodificador_salto
    import unidad_de_busqueda_pkg::*;
#(
    parameter logic [3:0] OPCODE_SALTO = c_opcode_salto
) (
    input  logic [3:0] i_opcode,
    input  logic [2:0] i_cond,
    input  logic [7:0] i_dir,
    output salto_t     o_salto
);

    logic w_es_salto;

    assign w_es_salto = (i_opcode == OPCODE_SALTO);

    always_comb begin
        o_salto = '0;
        if (w_es_salto) begin
            o_salto.condicion                 = {1'b1, i_cond};
            o_salto.condicion[c_bit_habilita] = 1'b1;
            o_salto.direccion                 = i_dir;
        end
    end

endmodule : decodificador_salto
`default_nettype wire

// File: rtl/unidad_de_busqueda.sv
`default_nettype none
// ============================================================================
// Module   : unidad_de_busqueda
// Brief    : Instruction fetch/decode front end closing the PC loop via jumps
// Revision : 1.0
// ============================================================================
module unidad_de_busqueda
    import unidad_de_busqueda_pkg::*;
#(
    parameter int         ANCHO_DIR    = 8,
    parameter int         ANCHO_INSTR  = 16,
    parameter logic [3:0] OPCODE_SALTO = c_opcode_salto,
    parameter int         ESPERA_MAX   = 15
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [ANCHO_DIR-1:0]   i_Bus_Direcciones_Instrucciones,
    input  logic                   i_Detener,
    output logic [ANCHO_DIR-1:0]   o_Mem_Direccion,
    output logic                   o_Mem_Lectura,
    input  logic [ANCHO_INSTR-1:0] i_Mem_Dato,
    input  logic                   i_Mem_Listo,
    output logic [ANCHO_INSTR-1:0] o_Instruccion,
    output logic                   o_Instruccion_Valida,
    output logic [ANCHO_DIR-1:0]   o_Direccion_de_Salto,
    output logic [3:0]             o_Condicion,
    output logic                   o_Error
);

    logic [c_ancho_estado-1:0] r_estado;
    logic [ANCHO_DIR-1:0]      r_mem_dir;
    logic [ANCHO_INSTR-1:0]    r_ir;
    logic [7:0]                r_cuenta;
    logic                      r_error;
    logic                      w_en_decode;
    salto_t                    w_salto;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_estado  <= c_st_idle;
            r_mem_dir <= '0;
            r_ir      <= '0;
            r_cuenta  <= 8'd0;
            r_error   <= 1'b0;
        end else begin
            case (r_estado)
                c_st_idle: begin
                    if (!i_Detener) begin
                        r_estado  <= c_st_req;
                        r_mem_dir <= i_Bus_Direcciones_Instrucciones;
                    end
                end
                c_st_req: begin
                    if (i_Mem_Listo) begin
                        r_ir     <= i_Mem_Dato;
                        r_estado <= c_st_decode;
                    end else begin
                        r_estado <= c_st_wait;
                        r_cuenta <= 8'd1;
                    end
                end
                c_st_wait: begin
                    // A late ready on the timeout cycle still completes the fetch.
                    if (i_Mem_Listo) begin
                        r_ir     <= i_Mem_Dato;
                        r_estado <= c_st_decode;
                        r_cuenta <= 8'd0;
                    end else if (r_cuenta == 8'(ESPERA_MAX)) begin
                        r_error  <= 1'b1;
                        r_cuenta <= 8'd0;
                        r_estado <= c_st_req;
                    end else begin
                        r_cuenta <= r_cuenta + 8'd1;
                    end
                end
                c_st_decode: r_estado <= c_st_idle;
                default:     r_estado <= c_st_idle;
            endcase
        end
    end

    decodificador_salto #(
        .OPCODE_SALTO (OPCODE_SALTO)
    ) u_decodificador_salto (
        .i_opcode (r_ir[c_opc_msb:c_opc_lsb]),
        .i_cond   (r_ir[c_cond_msb:c_cond_lsb]),
        .i_dir    (r_ir[c_dir_msb:c_dir_lsb]),
        .o_salto  (w_salto)
    );

    assign w_en_decode          = (r_estado == c_st_decode);
    assign o_Mem_Direccion      = r_mem_dir;
    assign o_Mem_Lectura        = (r_estado == c_st_req) || (r_estado == c_st_wait);
    assign o_Instruccion        = r_ir;
    assign o_Instruccion_Valida = w_en_decode;
    assign o_Condicion          = w_en_decode ? w_salto.condicion : 4'b0000;
    assign o_Direccion_de_Salto = w_en_decode ? ANCHO_DIR'(w_salto.direccion) : '0;
    assign o_Error              = r_error;

endmodule : unidad_de_busqueda
`default_nettype wire

// File: tb/tb_unidad_de_busqueda.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidad_de_busqueda
// Brief    : Directed + randomized bench for unidad_de_busqueda with a fetch model
// Revision : 1.0
// ============================================================================
module tb_unidad_de_busqueda;

    localparam int c_espera_max = 15;

    logic        Clk;
    logic        Rst;
    logic [7:0]  pc;
    logic        detener;
    logic [7:0]  mem_dir;
    logic        mem_lectura;
    logic [15:0] mem_dato;
    logic        mem_listo;
    logic [15:0] instr;
    logic        instr_valida;
    logic [7:0]  dir_salto;
    logic [3:0]  condicion;
    logic        error_flag;

    int checks = 0;
    int errors = 0;
    bit done   = 0;

    unidad_de_busqueda #(
        .ANCHO_DIR    (8),
        .ANCHO_INSTR  (16),
        .OPCODE_SALTO (4'hF),
        .ESPERA_MAX   (c_espera_max)
    ) dut (
        .Clk                             (Clk),
        .Rst                             (Rst),
        .i_Bus_Direcciones_Instrucciones (pc),
        .i_Detener                       (detener),
        .o_Mem_Direccion                 (mem_dir),
        .o_Mem_Lectura                   (mem_lectura),
        .i_Mem_Dato                      (mem_dato),
        .i_Mem_Listo                     (mem_listo),
        .o_Instruccion                   (instr),
        .o_Instruccion_Valida            (instr_valida),
        .o_Direccion_de_Salto            (dir_salto),
        .o_Condicion                     (condicion),
        .o_Error                         (error_flag)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a fetch is a run of attempt cycles, attempt 0
    // being the request and 1..ESPERA_MAX the waits; decode is one cycle.
    bit          m_fetching = 0;
    bit          m_decode   = 0;
    int          m_attempt  = 0;
    logic [7:0]  m_addr     = 8'h00;
    logic [15:0] m_ir       = 16'h0000;
    bit          m_err      = 0;

    task automatic model_step();
        if (!Rst) begin
            m_fetching = 0; m_decode = 0; m_attempt = 0;
            m_addr = 8'h00; m_ir = 16'h0000; m_err = 0;
        end else if (m_decode) begin
            m_decode = 0;
        end else if (m_fetching) begin
            if (mem_listo) begin
                m_ir = mem_dato; m_fetching = 0; m_decode = 1; m_attempt = 0;
            end else if (m_attempt == c_espera_max) begin
                m_err = 1; m_attempt = 0;
            end else begin
                m_attempt++;
            end
        end else if (!detener) begin
            m_fetching = 1; m_attempt = 0; m_addr = pc;
        end
    endtask

    task automatic compare();
        bit         jump;
        logic [3:0] exp_cond;
        logic [7:0] exp_dir;
        jump     = m_decode && (m_ir[15:12] == 4'hF);
        exp_cond = jump ? {1'b1, m_ir[10:8]} : 4'b0000;
        exp_dir  = jump ? m_ir[7:0] : 8'h00;
        chk("mem_dir",   32'(mem_dir),      32'(m_addr));
        chk("lectura",   32'(mem_lectura),  32'(m_fetching));
        chk("instr",     32'(instr),        32'(m_ir));
        chk("valida",    32'(instr_valida), 32'(m_decode));
        chk("condicion", 32'(condicion),    32'(exp_cond));
        chk("dir_salto", 32'(dir_salto),    32'(exp_dir));
        chk("error",     32'(error_flag),   32'(m_err));
    endtask

    initial begin : model_and_compare
        forever begin
            @(posedge Clk);
            model_step();
            @(negedge Clk);
            if (!done) compare();
        end
    end

    task automatic cyc();
        @(negedge Clk);
        #1;
    endtask

    initial begin : stimulus
        int mode;
        Rst = 1'b0; detener = 1'b1; mem_listo = 1'b0; pc = 8'h00; mem_dato = 16'h0000;
        cyc(); cyc();
        chk("rst_lectura", 32'(mem_lectura), 32'd0);
        chk("rst_instr",   32'(instr),       32'd0);
        chk("rst_error",   32'(error_flag),  32'd0);

        // Zero-wait fetch
        Rst = 1'b1; detener = 1'b0; pc = 8'h07;
        cyc();
        chk("t2_lectura", 32'(mem_lectura), 32'd1);
        chk("t2_dir",     32'(mem_dir),     32'h07);
        mem_listo = 1'b1; mem_dato = 16'h1234; detener = 1'b1;
        cyc();
        chk("t2_instr",  32'(instr),        32'h1234);
        chk("t2_valida", 32'(instr_valida), 32'd1);
        chk("t2_cond",   32'(condicion),    32'd0);
        mem_listo = 1'b0; detener = 1'b0; pc = 8'h20;
        cyc();
        chk("t2_pulse", 32'(instr_valida), 32'd0);

        // Jump decode after 3 wait cycles
        cyc();
        chk("t3_dir", 32'(mem_dir), 32'h20);
        cyc(); cyc(); cyc();
        mem_listo = 1'b1; mem_dato = 16'hF507;
        cyc();
        chk("t3_cond",   32'(condicion),    32'hD);
        chk("t3_target", 32'(dir_salto),    32'h07);
        chk("t3_valida", 32'(instr_valida), 32'd1);
        mem_listo = 1'b0; pc = 8'h07;
        cyc();
        chk("t3_cond_off", 32'(condicion), 32'd0);
        chk("t3_dir_off",  32'(dir_salto), 32'd0);
        cyc();
        chk("t3_newpc", 32'(mem_dir), 32'h07);

        // Timeout and retry of the same address
        for (int i = 1; i <= c_espera_max; i++) begin
            cyc();
            chk("t4_no_err_yet", 32'(error_flag), 32'd0);
        end
        cyc();
        chk("t4_error", 32'(error_flag),  32'd1);
        chk("t4_retry", 32'(mem_lectura), 32'd1);
        chk("t4_addr",  32'(mem_dir),     32'h07);
        mem_listo = 1'b1; mem_dato = 16'h0ABC; detener = 1'b1;
        cyc();
        chk("t4_instr",  32'(instr),      32'h0ABC);
        chk("t4_sticky", 32'(error_flag), 32'd1);
        mem_listo = 1'b0;

        // Stall parks in IDLE
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_stall", 32'(mem_lectura), 32'd0);
        end
        pc = 8'hFF; detener = 1'b0;
        cyc();
        chk("t6_ff", 32'(mem_dir), 32'hFF);
        mem_listo = 1'b1; mem_dato = 16'h1111; detener = 1'b1;
        cyc();
        cyc();
        chk("t6_idle_listo", 32'(instr_valida), 32'd0);
        cyc();
        chk("t6_idle_listo2", 32'(instr_valida), 32'd0);
        pc = 8'h00; detener = 1'b0; mem_listo = 1'b0;
        cyc();
        chk("t6_00",    32'(mem_dir),     32'h00);
        chk("t6_lect",  32'(mem_lectura), 32'd1);
        mem_listo = 1'b1; mem_dato = 16'h2222;
        cyc();
        chk("t6_instr", 32'(instr), 32'h2222);

        // Asynchronous reset in the middle of a wait
        mem_listo = 1'b0; pc = 8'h40;
        cyc(); cyc(); cyc(); cyc();
        Rst = 1'b0;
        #1;
        chk("t1_async_lect",  32'(mem_lectura), 32'd0);
        chk("t1_async_err",   32'(error_flag),  32'd0);
        chk("t1_async_dir",   32'(mem_dir),     32'd0);
        chk("t1_async_instr", 32'(instr),       32'd0);
        cyc(); cyc();
        Rst = 1'b1; pc = 8'h55;
        chk("t1_idle", 32'(mem_lectura), 32'd0);
        cyc();
        chk("t1_req", 32'(mem_dir), 32'h55);

        // Randomized traffic
        mode = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 40 == 0) mode = $urandom_range(0, 3);
            Rst       = ($urandom_range(0, 499) != 0);
            detener   = ($urandom_range(0, 3) == 0);
            mem_listo = (mode == 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
            pc        = 8'($urandom);
            mem_dato  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) mem_dato[15:12] = 4'hF;
            cyc();
        end

        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_unidad_de_busqueda
`default_nettype wire
